// File: rtl/fxp_multiplier.sv
// rtl/fxp_multiplier.sv - sequential signed fixed-point multiplier, shift-add with round-to-nearest-even (optional MUL_SATURATE_EN)
module fxp_multiplier #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    output logic [WIDTH-1:0] val
);

    // Magnitude width, accumulator width, rounded-quotient width, counter width
    localparam int MW = WIDTH - 1;
    localparam int AW = 2 * MW;
    localparam int RW = AW - FBITS + 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_SIGN  = 3'd4;

    localparam logic [WIDTH-1:0] SMALLEST    = {1'b1, {MW{1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS     = {1'b0, {MW{1'b1}}};
    localparam logic [WIDTH-1:0] MIN_SAT     = {1'b1, {(MW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    STICKY_MASK = (AW'(1) << (FBITS - 1)) - AW'(1);
    localparam logic [CW-1:0]    LAST_ITER   = CW'(WIDTH - 2);

    logic [2:0]       state;
    logic [MW-1:0]    au;
    logic [MW-1:0]    bu;
    logic             sign;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [MW-1:0]    r_q;
    logic             ovf_q;

    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic [RW-1:0]    r_trunc;
    logic [RW-1:0]    r_rnd;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic             r_ovf;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] signed_val;
    logic             shortcut;

    // Operand negation, rounding of the accumulated product, and sign application
    always_comb begin
        neg_a      = -a;
        neg_b      = -b;
        shortcut   = (a == SMALLEST) || (b == SMALLEST);
        r_trunc    = {1'b0, acc[AW-1:FBITS]};
        guard      = acc[FBITS-1];
        sticky     = |(acc & STICKY_MASK);
        round_up   = guard && (sticky || r_trunc[0]);
        r_rnd      = r_trunc + RW'(round_up);
        r_ovf      = |r_rnd[RW-1:MW];
        mag        = {1'b0, r_q};
        signed_val = sign ? -mag : mag;
    end

    // Control FSM and datapath: capture, shift-add, round, sign/complete
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            val   <= '0;
            au    <= '0;
            bu    <= '0;
            sign  <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        valid <= 1'b0;
                        ovf   <= 1'b0;
                        if (shortcut) begin
                            done <= 1'b1;
                            ovf  <= 1'b1;
`ifdef MUL_SATURATE_EN
                            val   <= (a[MW] ^ b[MW]) ? MIN_SAT : MAX_POS;
                            valid <= 1'b1;
`else
                            val   <= MAX_POS;
`endif
                        end else begin
                            au    <= a[MW] ? neg_a[MW-1:0] : a[MW-1:0];
                            bu    <= b[MW] ? neg_b[MW-1:0] : b[MW-1:0];
                            sign  <= a[MW] ^ b[MW];
                            busy  <= 1'b1;
                            state <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    acc   <= '0;
                    cnt   <= '0;
                    mcand <= {{MW{1'b0}}, au};
                    state <= S_CALC;
                end
                S_CALC: begin
                    if (bu[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    bu    <= bu >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_q   <= r_rnd[MW-1:0];
                    ovf_q <= r_ovf;
                    state <= S_SIGN;
                end
                S_SIGN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (!ovf_q) begin
                        val   <= signed_val;
                        valid <= 1'b1;
                        ovf   <= 1'b0;
                    end else begin
                        ovf <= 1'b1;
`ifdef MUL_SATURATE_EN
                        val   <= sign ? MIN_SAT : MAX_POS;
                        valid <= 1'b1;
`else
                        val   <= MAX_POS;
                        valid <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_multiplier.sv
// tb/tb_fxp_multiplier.sv - self-checking bench for fxp_multiplier (Q16.16), honours MUL_SATURATE_EN
module tb_fxp_multiplier;

`ifdef MUL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] OVF_POS   = 32'h7FFFFFFF;
    localparam logic [31:0] OVF_NEG   = SAT ? 32'h80000001 : 32'h7FFFFFFF;
    localparam logic        OVF_VALID = SAT;
    localparam int          LAT       = 34;

    typedef struct {
        logic [31:0] val;
        logic        valid;
        logic        ovf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        valid;
    logic        ovf;
    logic [31:0] val;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    fxp_multiplier #(.WIDTH(32), .FBITS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .ovf   (ovf),
        .val   (val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] v, input logic vl, input logic o, input int l);
        exp_t e;
        e.val = v; e.valid = vl; e.ovf = o; e.lat = l;
        return e;
    endfunction

    // Reference: exact 64-bit product, round half to even on the magnitude
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      p;
        logic [63:0] m;
        logic [63:0] r;
        logic        sg;
        sg = x[31] ^ y[31];
        if (x == 32'h80000000 || y == 32'h80000000)
            return mk(sg ? OVF_NEG : OVF_POS, OVF_VALID, 1'b1, 0);
        p = longint'($signed(x)) * longint'($signed(y));
        m = (p < 0) ? 64'(-p) : 64'(p);
        r = m >> 16;
        if (m[15] && ((m[14:0] != 15'd0) || r[0])) r = r + 64'd1;
        if (r >= 64'h80000000)
            e = mk(sg ? OVF_NEG : OVF_POS, OVF_VALID, 1'b1, LAT);
        else
            e = mk(sg ? 32'(-r) : r[31:0], 1'b1, 1'b0, LAT);
        return e;
    endfunction

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input exp_t e, input int inject_at);
        exp_t got;
        int   lat;
        bit   busy_ok;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == inject_at) begin
                start = 1'b1; a = 32'h00050000; b = 32'h00070000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        got = sb.pop_front();
        check("val", val, got.val);
        check("valid", valid, got.valid);
        check("ovf", ovf, got.ovf);
        check("latency", lat, got.lat);
        check("busy_at_done", busy, 1'b0);
        if (got.lat > 0) check("busy_during_op", busy_ok, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("val_held", val, got.val);
    endtask

    initial begin
        int n_done;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_val", val, 32'h0);
        rst = 1'b0;

        run_op(32'h00020000, 32'h00030000, mk(32'h00060000, 1'b1, 1'b0, LAT), -1);
        run_op(32'hFFFE8000, 32'h00028000, mk(32'hFFFC4000, 1'b1, 1'b0, LAT), -1);
        run_op(32'h00000001, 32'h00008000, mk(32'h00000000, 1'b1, 1'b0, LAT), -1);
        run_op(32'h00000003, 32'h00008000, mk(32'h00000002, 1'b1, 1'b0, LAT), -1);
        run_op(32'hFFFFFFFD, 32'h00008000, mk(32'hFFFFFFFE, 1'b1, 1'b0, LAT), -1);
        run_op(32'h00000000, 32'h12345678, mk(32'h00000000, 1'b1, 1'b0, LAT), -1);
        run_op(32'h01000000, 32'h01000000, mk(OVF_POS, OVF_VALID, 1'b1, LAT), -1);
        run_op(32'h01000000, 32'hFF000000, mk(OVF_NEG, OVF_VALID, 1'b1, LAT), -1);
        run_op(32'h80000000, 32'h00010000, mk(OVF_NEG, OVF_VALID, 1'b1, 0), -1);
        run_op(32'h00010000, 32'h80000000, mk(OVF_NEG, OVF_VALID, 1'b1, 0), -1);
        run_op(32'h00018000, 32'hFFFF0000, mk(32'hFFFE8000, 1'b1, 1'b0, LAT), -1);

        // second start 5 cycles in must not disturb the running product
        run_op(32'h00040000, 32'h00024000, mk(32'h00090000, 1'b1, 1'b0, LAT), 5);

        // reset mid-calculation aborts without a done pulse
        @(negedge clk);
        a = 32'h00030000; b = 32'h00030000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_valid", valid, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        check("abort_val", val, 32'h0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        run_op(32'h00030000, 32'h00030000, mk(32'h00090000, 1'b1, 1'b0, LAT), -1);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom >> $urandom_range(8, 20);
            rb = $urandom >> $urandom_range(8, 20);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op(ra, rb, model(ra, rb), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
